proj_tile_engine: RTL

- Parametrised successor to the fixed 4x4 projection controller: computes OUT[M_T*N x NUM_TILES*N] = A x W + bias with int8 operands, one N x N output tile at a time.
- Owns its MAC array: one outer-product step per cycle into internal accumulators. Fetches operands and per-tile bias from 1-cycle-latency SRAMs, then writes each finished tile row by row to output SRAM.
- Adds base-address relocation (Q/K/V/heads reuse one instance), start/busy/done handshake, and a selectable raw-int32 or requantised-int8 output mode.

---
 rtl/proj_tile_engine.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/proj_tile_engine.sv
// Tiled int8 projection engine: OUT = A x W + bias, one N x N tile at a time.
// Operands and bias come from 1-cycle-latency SRAMs; each finished tile is
// written row by row, either as raw int32 or requantised int8.
module proj_tile_engine #(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int ACC_W     = 32,
   parameter int K_LEN     = 128,
   parameter int NUM_TILES = 32,
   parameter int A_AW      = 8,
   parameter int W_AW      = 13,
   parameter int B_AW      = 6,
   parameter int O_AW      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [4:0]           shift,
   input  logic [A_AW-1:0]      a_base,
   input  logic [W_AW-1:0]      w_base,
   input  logic [B_AW-1:0]      b_base,
   input  logic [O_AW-1:0]      o_base,
   output logic                 busy,
   output logic                 done,
   output logic                 a_ceb,
   output logic [A_AW-1:0]      a_addr,
   input  logic [N*DW-1:0]      a_dout,
   output logic                 w_ceb,
   output logic [W_AW-1:0]      w_addr,
   input  logic [N*DW-1:0]      w_dout,
   output logic                 b_ceb,
   output logic [B_AW-1:0]      b_addr,
   input  logic [N*ACC_W-1:0]   b_dout,
   output logic                 o_ceb,
   output logic                 o_wen,
   output logic [O_AW-1:0]      o_addr,
   output logic [N*ACC_W-1:0]   o_din
);

   localparam int CW = $clog2(K_LEN + 1);
   localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(K_LEN);
   localparam logic [TW-1:0] T_LAST = TW'(NUM_TILES - 1);
   localparam logic [RW-1:0] R_LAST = RW'(N - 1);
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

   typedef enum logic [2:0] {IDLE, PRE, MAC, WR, FIN} state_t;

   state_t state, state_nxt;

   logic [TW-1:0]   t_idx;
   logic [CW-1:0]   c_idx;
   logic [RW-1:0]   r_idx;
   logic            cfg_mode;
   logic [4:0]      cfg_shift;
   logic [A_AW-1:0] cfg_a_base;
   logic [W_AW-1:0] cfg_w_base;
   logic [B_AW-1:0] cfg_b_base;
   logic [O_AW-1:0] cfg_o_base;

   logic signed [DW-1:0]    a_lane_p0 [N];
   logic signed [DW-1:0]    w_lane_p0 [N];
   logic signed [2*DW-1:0]  prod_p0   [N][N];
   logic signed [ACC_W-1:0] acc_p1    [N][N];

   // Round-half-up arithmetic shift followed by clamp to the int8 range.
   // The sum is kept one bit wider so the rounding term can never overflow.
   function automatic logic [ACC_W-1:0] requant(input logic signed [ACC_W-1:0] v,
                                                input logic [4:0] sh);
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] sum;
      logic signed [ACC_W:0] shd;
      rnd = '0;
      if (sh != 5'd0) rnd = (ACC_W+1)'(1) << (sh - 5'd1);
      sum = $signed({v[ACC_W-1], v}) + rnd;
      shd = sum >>> sh;
      if (shd > SAT_HI)      shd = SAT_HI;
      else if (shd < SAT_LO) shd = SAT_LO;
      return shd[ACC_W-1:0];
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and memory-side control/addresses.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      a_ceb     = 1'b1;
      w_ceb     = 1'b1;
      b_ceb     = 1'b1;
      o_ceb     = 1'b1;
      o_wen     = 1'b1;
      a_addr    = '0;
      w_addr    = '0;
      b_addr    = '0;
      o_addr    = '0;
      case (state)
         IDLE: begin
            if (start) state_nxt = PRE;
         end
         PRE: begin
            busy      = 1'b1;
            b_ceb     = 1'b0;
            b_addr    = cfg_b_base + B_AW'(t_idx);
            state_nxt = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (c_idx != C_LAST) begin
               a_ceb  = 1'b0;
               w_ceb  = 1'b0;
               a_addr = cfg_a_base + A_AW'(c_idx);
               w_addr = cfg_w_base + W_AW'(c_idx) * W_AW'(NUM_TILES) + W_AW'(t_idx);
            end else begin
               state_nxt = WR;
            end
         end
         WR: begin
            busy   = 1'b1;
            o_ceb  = 1'b0;
            o_wen  = 1'b0;
            o_addr = cfg_o_base + O_AW'(t_idx) * O_AW'(N) + O_AW'(r_idx);
            if (r_idx == R_LAST) state_nxt = (t_idx == T_LAST) ? FIN : PRE;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Tile/step/row counters and run configuration captured at start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_idx      <= '0;
         c_idx      <= '0;
         r_idx      <= '0;
         cfg_mode   <= 1'b0;
         cfg_shift  <= '0;
         cfg_a_base <= '0;
         cfg_w_base <= '0;
         cfg_b_base <= '0;
         cfg_o_base <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  t_idx      <= '0;
                  cfg_mode   <= mode;
                  cfg_shift  <= shift;
                  cfg_a_base <= a_base;
                  cfg_w_base <= w_base;
                  cfg_b_base <= b_base;
                  cfg_o_base <= o_base;
               end
            end
            PRE: c_idx <= '0;
            MAC: begin
               if (c_idx == C_LAST) r_idx <= '0;
               else                 c_idx <= c_idx + 1'b1;
            end
            WR: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == R_LAST && t_idx != T_LAST) t_idx <= t_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Operand lanes returned by the SRAMs and their outer product.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_lane_p0[i] = $signed(a_dout[i*DW +: DW]);
         w_lane_p0[i] = $signed(w_dout[i*DW +: DW]);
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            prod_p0[i][j] = (2*DW)'(a_lane_p0[i]) * (2*DW)'(w_lane_p0[j]);
   end

   // ---- stage p0 -> p1: bias preload on step 0, wrapping MAC afterwards ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               acc_p1[i][j] <= '0;
      end else if (state == MAC) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (c_idx == '0) acc_p1[i][j] <= $signed(b_dout[j*ACC_W +: ACC_W]);
               else             acc_p1[i][j] <= acc_p1[i][j] + ACC_W'(prod_p0[i][j]);
      end
   end

   // Output row formatting; zero whenever no row is being written.
   always_comb begin
      o_din = '0;
      if (state == WR) begin
         for (int j = 0; j < N; j++)
            o_din[j*ACC_W +: ACC_W] = cfg_mode ? requant(acc_p1[r_idx][j], cfg_shift)
                                               : acc_p1[r_idx][j];
      end
   end

endmodule
